instr_mem_ctrl: RTL and testbench

Parametrised instruction memory for the single-cycle RISC-V core. It replaces the fixed 64-word fetch array with a configurable-depth store that has a valid/ready fetch port and a 1-cycle registered response. Alignment and range faults are reported per fetch, and a program-load write port is provided. On reset a hardware init sequencer fills every word with a NOP, so the core never fetches undefined data.

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/imem_sdp_ram.sv | 56 +++++
 rtl/instr_mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_instr_mem_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the RISC-V instruction memory.
// Fault codes and controller states live here so the core can decode them.
package riscv_mem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'd0,
        FAULT_MISALIGNED = 2'd1,
        FAULT_RANGE      = 2'd2
    } fetch_fault_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_sdp_ram.sv
// Simple dual-port instruction RAM: one write port, one registered read port with enable.
// Out-of-range writes are dropped so non-power-of-two depths stay safe.
module imem_sdp_ram #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 64,
    parameter logic [XLEN-1:0] RESET_WORD = '0,
    localparam int             AW         = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_d;
    logic            wr_in_range;

    assign wr_in_range = ({1'b0, waddr} < DEPTH_W);

    // Storage write; the array itself is refilled by the init sequencer, not reset.
    always_ff @(posedge clk) begin
        if (we && wr_in_range) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds unless a new read is enabled (keeps the response stable under stall).
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= RESET_WORD;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: NOP fill after reset, program-load port,
// valid/ready fetch port with a one-cycle registered response and fault reporting.
module instr_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 64,
    parameter int              ADDR_W      = 32,
    parameter logic [XLEN-1:0] RESET_INSTR = XLEN'(NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [XLEN-1:0]          load_data,
    input  logic                     fetch_req_valid,
    output logic                     fetch_req_ready,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_rsp_valid,
    input  logic                     fetch_rsp_ready,
    output logic [XLEN-1:0]          fetch_instr,
    output logic [1:0]               fetch_fault,
    output logic                     init_done
);

    localparam int                AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]     LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W - 2)'(DEPTH);

    imem_state_t     state_q, state_d;
    logic [AW-1:0]   fill_cnt_q, fill_cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    fetch_fault_t    rsp_fault_q, rsp_fault_d;

    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [XLEN-1:0] ram_wdata;
    logic            ram_re;
    logic [XLEN-1:0] ram_rdata;

    logic [ADDR_W-3:0] fetch_idx;
    fetch_fault_t      fetch_fault_c;
    logic              fetch_accept;

    // State, fill counter and response bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            fill_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= FAULT_NONE;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Next state and write-port mux: the sequencer owns the port in INIT, the loader in RUN.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        ram_we     = 1'b0;
        ram_waddr  = load_addr;
        ram_wdata  = load_data;
        case (state_q)
            INIT: begin
                ram_we    = 1'b1;
                ram_waddr = fill_cnt_q;
                ram_wdata = RESET_INSTR;
                if (fill_cnt_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    fill_cnt_d = fill_cnt_q + AW'(1);
                end
            end
            RUN: begin
                ram_we = load_valid;
            end
            default: begin
                state_d    = INIT;
                fill_cnt_d = '0;
            end
        endcase
    end

    assign load_ready      = (state_q == RUN);
    assign init_done       = (state_q == RUN);
    assign fetch_req_ready = (state_q == RUN) && (!rsp_valid_q || fetch_rsp_ready);
    assign fetch_accept    = fetch_req_valid && fetch_req_ready;
    assign fetch_idx       = fetch_addr[ADDR_W-1:2];

    // Fault decode: misalignment takes priority over range.
    always_comb begin
        fetch_fault_c = FAULT_NONE;
        if (fetch_addr[1:0] != 2'b00) begin
            fetch_fault_c = FAULT_MISALIGNED;
        end else if (fetch_idx >= DEPTH_IDX) begin
            fetch_fault_c = FAULT_RANGE;
        end else begin
            fetch_fault_c = FAULT_NONE;
        end
    end

    assign ram_re = fetch_accept && (fetch_fault_c == FAULT_NONE);

    // Response register: load on accept, drop on a bare handshake, otherwise hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        if (fetch_accept) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = fetch_fault_c;
        end else if (fetch_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    imem_sdp_ram #(
        .XLEN       (XLEN),
        .DEPTH      (DEPTH),
        .RESET_WORD (RESET_INSTR)
    ) u_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (fetch_idx[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign fetch_rsp_valid = rsp_valid_q;
    assign fetch_fault     = rsp_fault_q;
    assign fetch_instr     = (rsp_fault_q == FAULT_NONE) ? ram_rdata : RESET_INSTR;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_instr_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [31:0] fetch_addr;
    logic        fetch_rsp_valid;
    logic        fetch_rsp_ready;
    logic [31:0] fetch_instr;
    logic [1:0]  fetch_fault;
    logic        init_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [33:0] sb[$];

    instr_mem_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_ready (fetch_req_ready),
        .fetch_addr      (fetch_addr),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_ready (fetch_rsp_ready),
        .fetch_instr     (fetch_instr),
        .fetch_fault     (fetch_fault),
        .init_done       (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed when valid and ready are both high before the edge.
    always @(negedge clk) begin
        if (!reset && fetch_rsp_valid && fetch_rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", {30'd0, fetch_rsp_valid}, 32'd0);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                check("rsp_instr", fetch_instr, e[31:0]);
                check("rsp_fault", {30'd0, fetch_fault}, {30'd0, e[33:32]});
            end
        end
    end

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_instr,
                            input logic [1:0] exp_fault);
        int waited = 0;
        fetch_req_valid = 1'b1;
        fetch_addr      = addr;
        @(negedge clk);
        while (!fetch_req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!fetch_req_ready) begin
            check("fetch_accept_timeout", 32'(waited), 32'd0);
            fetch_req_valid = 1'b0;
        end else begin
            sb.push_back({exp_fault, exp_instr});
            @(posedge clk);
            #1;
            fetch_req_valid = 1'b0;
        end
    endtask

    task automatic do_load(input logic [5:0] addr, input logic [31:0] data);
        load_valid = 1'b1;
        load_addr  = addr;
        load_data  = data;
        @(negedge clk);
        check("load_ready", {31'd0, load_ready}, 32'd1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (init_done) break;
        end
        check(name, 32'(n), 32'd64);
    endtask

    initial begin
        reset           = 1'b1;
        load_valid      = 1'b0;
        load_addr       = 6'd0;
        load_data       = 32'd0;
        fetch_req_valid = 1'b0;
        fetch_addr      = 32'd0;
        fetch_rsp_ready = 1'b1;

        #12;
        check("rst_rsp_valid",   {31'd0, fetch_rsp_valid}, 32'd0);
        check("rst_instr",       fetch_instr, 32'h0000_0013);
        check("rst_fault",       {30'd0, fetch_fault}, 32'd0);
        check("rst_req_ready",   {31'd0, fetch_req_ready}, 32'd0);
        check("rst_load_ready",  {31'd0, load_ready}, 32'd0);
        check("rst_init_done",   {31'd0, init_done}, 32'd0);
        #10;
        reset = 1'b0;
        wait_init("init_cycles");

        do_fetch(32'h0000_0000, 32'h0000_0013, 2'd0);
        do_fetch(32'h0000_007C, 32'h0000_0013, 2'd0);
        do_fetch(32'h0000_00FC, 32'h0000_0013, 2'd0);

        do_load(6'd3, 32'h0050_0093);
        do_fetch(32'h0000_000C, 32'h0050_0093, 2'd0);
        do_fetch(32'h0000_000E, 32'h0000_0013, 2'd1);
        do_fetch(32'h0000_0100, 32'h0000_0013, 2'd2);
        do_fetch(32'h0000_0003, 32'h0000_0013, 2'd1);

        // Backpressure: three stalled cycles after the first of three back-to-back fetches.
        do_load(6'd0, 32'h0010_0093);
        do_load(6'd1, 32'h0020_0093);
        do_load(6'd2, 32'h0030_0093);
        fork
            begin
                do_fetch(32'h0000_0000, 32'h0010_0093, 2'd0);
                do_fetch(32'h0000_0004, 32'h0020_0093, 2'd0);
                do_fetch(32'h0000_0008, 32'h0030_0093, 2'd0);
            end
            begin
                int w = 0;
                while (w < 20) begin
                    @(posedge clk);
                    #1;
                    w++;
                    if (fetch_rsp_valid) break;
                end
                fetch_rsp_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_req_ready", {31'd0, fetch_req_ready}, 32'd0);
                    check("stall_rsp_valid", {31'd0, fetch_rsp_valid}, 32'd1);
                    check("stall_instr",     fetch_instr, 32'h0010_0093);
                    check("stall_fault",     {30'd0, fetch_fault}, 32'd0);
                end
                @(posedge clk);
                #1;
                fetch_rsp_ready = 1'b1;
            end
        join

        // Same-cycle load and fetch of word 5: read-before-write.
        load_valid = 1'b1;
        load_addr  = 6'd5;
        load_data  = 32'hDEAD_BEEF;
        do_fetch(32'h0000_0014, 32'h0000_0013, 2'd0);
        load_valid = 1'b0;
        do_fetch(32'h0000_0014, 32'hDEAD_BEEF, 2'd0);

        // Reset with a response pending and the program loaded.
        @(negedge clk);
        @(posedge clk);
        #1;
        fetch_rsp_ready = 1'b0;
        do_fetch(32'h0000_000C, 32'h0050_0093, 2'd0);
        #2;
        check("pend_rsp_valid", {31'd0, fetch_rsp_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_rsp_valid", {31'd0, fetch_rsp_valid}, 32'd0);
        check("midrst_req_ready", {31'd0, fetch_req_ready}, 32'd0);
        check("midrst_init_done", {31'd0, init_done}, 32'd0);
        check("midrst_instr",     fetch_instr, 32'h0000_0013);
        sb.delete();
        @(negedge clk);
        #2;
        reset = 1'b0;
        fetch_rsp_ready = 1'b1;
        wait_init("reinit_cycles");
        do_fetch(32'h0000_000C, 32'h0000_0013, 2'd0);
        do_fetch(32'h0000_0014, 32'h0000_0013, 2'd0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
